ifetch_stage: RTL
=================

Name: ifetch_stage

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Owns the architectural PC register and issues word fetches to instruction memory over a req/ack handshake.
- Delivers fetched instructions to the decode stage through a registered IF/ID output bank.
- Supports stall from decode and PC redirect (branch/jump) from the execute stage.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset (MIPS text base).
- ADDR_W, 32, width of PC and memory address.
- NOP_INSTR, 32'h0000_0000, value driven on if_instr when flushed or in reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  decode cannot accept; hold IF/ID bank.
- redirect_valid  in  1  load new PC this cycle (branch taken / jump).
- redirect_pc  in  ADDR_W  target PC.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  ADDR_W  fetch address (= PC), registered.
- imem_ack  in  1  memory returns data this cycle for imem_addr.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- if_valid  out  1  IF/ID bank holds a live instruction.
- if_pc  out  ADDR_W  PC of the instruction in the IF/ID bank.
- if_pc_plus4  out  ADDR_W  if_pc+4, registered.
- if_instr  out  32  instruction word.

Behaviour:
- Reset (async, any time, including mid-fetch): pc=RESET_PC, state=S_IDLE, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_pc_plus4=0, if_instr=NOP_INSTR, hold buffer cleared.
- FSM states: S_IDLE, S_REQ, S_HOLD.
- S_IDLE:
  - imem_req=0.
  - First edge after reset release: go to S_REQ, imem_req=1, imem_addr=pc.
- S_REQ:
  - imem_req and imem_addr are held until ack.
  - No ack, no stall: if_valid<=0 (bubble).
  - ack and !stall_i: if_valid<=1, if_pc<=pc, if_pc_plus4<=pc+4, if_instr<=imem_rdata, pc<=pc+4, imem_addr<=pc+4; stay in S_REQ.
  - ack and stall_i: capture imem_rdata/pc in the hold buffer, imem_req<=0, go to S_HOLD. The IF/ID bank is unchanged.
- S_HOLD:
  - While stall_i=1: no requests; the IF/ID bank is held.
  - When stall_i=0: load the bank from the hold buffer (if_valid=1), pc<=pc+4, imem_req<=1, imem_addr<=pc+4, go to S_REQ.
- Stall in S_REQ without ack: the IF/ID bank is held and the request continues.
- Redirect has highest priority, in any non-reset state and regardless of stall_i:
  - pc<=redirect_pc and imem_addr<=redirect_pc.
  - Any same-cycle imem_ack is discarded.
  - if_valid<=0 and if_instr<=NOP_INSTR; the hold buffer is discarded.
  - imem_req<=1, state<=S_REQ.
- Latency:
  - With always-ack memory, the first if_valid=1 is at the 2nd rising edge after reset release.
  - Throughput is one instruction per cycle.
- Arithmetic: pc+4 is modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0x0000_0000). No other address checks unless the optional feature below is compiled in.
- Memory contract: imem_addr changes only on an ack edge, a redirect edge, or an S_HOLD exit.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output if_misalign (1 bit, reset 0).
  - A redirect_pc with [1:0]!=0 is still loaded, but no request is issued.
  - if_valid=1, if_misalign=1, if_pc=redirect_pc and if_instr=NOP_INSTR are presented on the next edge.
  - The FSM parks in S_IDLE until the next redirect.
- Not defined:
  - The port is absent.
  - redirect_pc[1:0] is ignored and forced to 2'b00 when loaded.

Test Plan:
- Reset release, imem_ack tied 1, imem_rdata=addr-derived -> edge 2: if_valid=1, if_pc=0x0040_0000; edge 3: if_pc=0x0040_0004, if_pc_plus4=0x0040_0008.
- imem_ack held low 3 cycles at 0x0040_0004 -> imem_addr stable 0x0040_0004, if_valid=0 for 3 cycles, then the instruction is delivered once (no duplicate).
- stall_i=1 for 4 cycles coincident with an ack -> IF/ID bank frozen, imem_req=0 during S_HOLD. After release, the held word appears exactly once, followed by the next sequential PC.
- redirect_valid=1, redirect_pc=0x0040_0100, same cycle as ack and stall_i=1 -> ack discarded, if_valid=0, next fetch address 0x0040_0100, next delivered if_pc=0x0040_0100.
- Redirect to 0xFFFF_FFFC with ack always 1 -> delivered PCs 0xFFFF_FFFC then 0x0000_0000.
- rst asserted asynchronously mid-S_HOLD -> all outputs at reset values immediately; the fetch restarts at 0x0040_0000.

Source files
------------

// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch stage: PC register, imem req/ack fetch FSM, IF/ID output bank.
// Optional redirect alignment check is compiled in with `define IFETCH_ALIGN_CHECK_EN.
module ifetch_stage #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic [31:0]       if_instr
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic              if_misalign
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_pc_inc;
    logic              r_req, w_req_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_valid, w_valid_nxt;
    logic [ADDR_W-1:0] r_if_pc, w_if_pc_nxt;
    logic [ADDR_W-1:0] r_if_pc4, w_if_pc4_nxt;
    logic [31:0]       r_instr, w_instr_nxt;
    logic [31:0]       r_hold_instr, w_hold_instr_nxt;
    logic [ADDR_W-1:0] r_hold_pc, w_hold_pc_nxt;
    logic              r_misalign, w_misalign_nxt;
    logic [ADDR_W-1:0] w_redir_pc;
    logic              w_redir_mis;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign w_redir_pc  = redirect_pc;
    assign w_redir_mis = |redirect_pc[1:0];
    assign if_misalign = r_misalign;
`else
    assign w_redir_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_redir_mis = 1'b0;
`endif

    assign w_pc_inc = r_pc + ADDR_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A misaligned redirect parks the FSM in S_IDLE until the next redirect.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = w_redir_mis ? S_IDLE : S_REQ;
        end else begin
            case (r_state)
                S_IDLE:  if (!r_misalign) w_state_nxt = S_REQ;
                S_REQ:   if (imem_ack && stall_i) w_state_nxt = S_HOLD;
                S_HOLD:  if (!stall_i) w_state_nxt = S_REQ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pc_nxt         = r_pc;
        w_req_nxt        = r_req;
        w_addr_nxt       = r_addr;
        w_valid_nxt      = r_valid;
        w_if_pc_nxt      = r_if_pc;
        w_if_pc4_nxt     = r_if_pc4;
        w_instr_nxt      = r_instr;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc_nxt    = r_hold_pc;
        w_misalign_nxt   = r_misalign;
        if (redirect_valid) begin
            w_pc_nxt         = w_redir_pc;
            w_addr_nxt       = w_redir_pc;
            w_req_nxt        = !w_redir_mis;
            w_valid_nxt      = w_redir_mis;
            w_instr_nxt      = NOP_INSTR;
            w_hold_instr_nxt = NOP_INSTR;
            w_hold_pc_nxt    = '0;
            w_misalign_nxt   = w_redir_mis;
            if (w_redir_mis) begin
                w_if_pc_nxt  = w_redir_pc;
                w_if_pc4_nxt = w_redir_pc + ADDR_W'(4);
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_misalign) begin
                        w_req_nxt  = 1'b1;
                        w_addr_nxt = r_pc;
                    end
                end
                S_REQ: begin
                    if (imem_ack && !stall_i) begin
                        w_valid_nxt  = 1'b1;
                        w_if_pc_nxt  = r_pc;
                        w_if_pc4_nxt = w_pc_inc;
                        w_instr_nxt  = imem_rdata;
                        w_pc_nxt     = w_pc_inc;
                        w_addr_nxt   = w_pc_inc;
                    end else if (imem_ack) begin
                        w_hold_instr_nxt = imem_rdata;
                        w_hold_pc_nxt    = r_pc;
                        w_req_nxt        = 1'b0;
                    end else if (!stall_i) begin
                        w_valid_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        w_valid_nxt  = 1'b1;
                        w_if_pc_nxt  = r_hold_pc;
                        w_if_pc4_nxt = r_hold_pc + ADDR_W'(4);
                        w_instr_nxt  = r_hold_instr;
                        w_pc_nxt     = w_pc_inc;
                        w_addr_nxt   = w_pc_inc;
                        w_req_nxt    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req        <= 1'b0;
            r_addr       <= RESET_PC;
            r_valid      <= 1'b0;
            r_if_pc      <= '0;
            r_if_pc4     <= '0;
            r_instr      <= NOP_INSTR;
            r_hold_instr <= NOP_INSTR;
            r_hold_pc    <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_req        <= w_req_nxt;
            r_addr       <= w_addr_nxt;
            r_valid      <= w_valid_nxt;
            r_if_pc      <= w_if_pc_nxt;
            r_if_pc4     <= w_if_pc4_nxt;
            r_instr      <= w_instr_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
            r_misalign   <= w_misalign_nxt;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign if_valid    = r_valid;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc4;
    assign if_instr    = r_instr;

endmodule
